// File: rtl/f64_conv_pkg.sv
// rtl/f64_conv_pkg.sv - shared types, field positions and classify helper for binary64 conversion
package f64_conv_pkg;

    typedef enum logic [1:0] {
        RNA   = 2'd0,
        RTZ   = 2'd1,
        FLOOR = 2'd2,
        CEIL  = 2'd3
    } rnd_mode_e;

    localparam int F64_EXP_BIAS = 1023;
    localparam int F64_SIGN_BIT = 63;
    localparam int F64_EXP_MSB  = 62;
    localparam int F64_EXP_LSB  = 52;
    localparam int F64_FRAC_MSB = 51;

    typedef struct packed {
        logic        sign;
        logic [10:0] exp;
        logic [52:0] sig;
        logic        is_zero;
        logic        is_nan;
        logic        is_inf;
    } f64_class_t;

    // Subnormals keep the hidden bit clear, so they always align to a magnitude below one.
    function automatic f64_class_t f64_classify(input logic [63:0] bits);
        f64_class_t  c;
        logic [10:0] e;
        logic [51:0] f;
        e = bits[F64_EXP_MSB:F64_EXP_LSB];
        f = bits[F64_FRAC_MSB:0];
        c.sign    = bits[F64_SIGN_BIT];
        c.exp     = e;
        c.sig     = {(e != 11'd0), f};
        c.is_zero = (e == 11'd0) && (f == 52'd0);
        c.is_nan  = (&e) && (f != 52'd0);
        c.is_inf  = (&e) && (f == 52'd0);
        return c;
    endfunction

endpackage

// File: rtl/f64_align_shift.sv
// rtl/f64_align_shift.sv - aligns a binary64 significand to an integer magnitude with guard and sticky
module f64_align_shift #(
    parameter int OUT_W = 96
) (
    input  logic [10:0]  bexp,
    input  logic [52:0]  sig,
    output logic [OUT_W:0] mag,
    output logic         guard,
    output logic         sticky,
    output logic         big
);

    localparam int WIDE_W = OUT_W + 54;
    localparam logic signed [12:0] OUT_W_S = 13'(OUT_W);

    logic signed [12:0] e;
    logic [WIDE_W-1:0]  wide;
    logic [5:0]         rsh;
    logic [10:0]        lsh;
    logic [52:0]        below;

    assign e = $signed({2'b00, bexp}) - 13'sd1023;

    always_comb begin
        wide   = {{(OUT_W+1){1'b0}}, sig};
        rsh    = '0;
        lsh    = '0;
        below  = '0;
        guard  = 1'b0;
        sticky = 1'b0;
        if (e < -13'sd1) begin
            wide   = '0;
            sticky = |sig;
        end else if (e == -13'sd1) begin
            wide   = '0;
            guard  = sig[52];
            sticky = |sig[51:0];
        end else if (e < 13'sd52) begin
            rsh    = 6'(13'sd52 - e);
            below  = (53'd1 << (rsh - 6'd1)) - 53'd1;
            guard  = sig[rsh - 6'd1];
            sticky = |(sig & below);
            wide   = wide >> rsh;
        end else begin
            // Bits pushed past the working range simply fall off, which gives modulo behaviour.
            lsh  = 11'(e - 13'sd52);
            wide = wide << lsh;
        end
    end

    assign mag = wide[OUT_W:0];
    // Integer part has bits above the magnitude register: certainly out of range.
    assign big = (e > OUT_W_S);

endmodule

// File: rtl/f64_to_int_pipe.sv
// rtl/f64_to_int_pipe.sv - three-stage binary64 to signed integer converter with valid/ready flow
module f64_to_int_pipe
    import f64_conv_pkg::*;
#(
    parameter int OUT_W    = 96,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [63:0]      in_bits,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_inexact,
    output logic             out_overflow,
    output logic             out_invalid
);

    localparam logic [OUT_W+1:0] ONE_W  = 1;
    localparam logic [OUT_W+1:0] HALF   = ONE_W << (OUT_W - 1);
    localparam logic [OUT_W-1:0] MAX_SI = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] MIN_SI = {1'b1, {(OUT_W-1){1'b0}}};

    logic v1, v2, v3;
    logic en1, en2, en3;

    f64_class_t s1_cls;
    rnd_mode_e  s1_mode;

    logic           s2_sign, s2_guard, s2_sticky, s2_big;
    logic           s2_zero, s2_nan, s2_inf;
    rnd_mode_e      s2_mode;
    logic [OUT_W:0] s2_mag;

    logic [OUT_W:0] al_mag;
    logic           al_guard, al_sticky, al_big;

    logic             inc, mag_ovf;
    logic [OUT_W+1:0] mag_r;
    logic [OUT_W-1:0] low, wrapped, clamp, res_data;
    logic             res_inexact, res_ovf, res_inv;

    // A stage may load when empty or when its occupant leaves in the same cycle.
    assign en3      = !v3 || out_ready;
    assign en2      = !v2 || en3;
    assign en1      = !v1 || en2;
    assign in_ready = en1;
    assign out_valid = v3;

    f64_align_shift #(.OUT_W(OUT_W)) u_align (
        .bexp   (s1_cls.exp),
        .sig    (s1_cls.sig),
        .mag    (al_mag),
        .guard  (al_guard),
        .sticky (al_sticky),
        .big    (al_big)
    );

    always_comb begin
        case (s2_mode)
            RNA:     inc = s2_guard;
            RTZ:     inc = 1'b0;
            FLOOR:   inc = s2_sign & (s2_guard | s2_sticky);
            default: inc = ~s2_sign & (s2_guard | s2_sticky);
        endcase
        mag_r   = {1'b0, s2_mag} + {{(OUT_W+1){1'b0}}, inc};
        // The negative side may reach exactly 2^(OUT_W-1).
        mag_ovf = s2_big || (s2_sign ? (mag_r > HALF) : (mag_r >= HALF));
        low     = mag_r[OUT_W-1:0];
        wrapped = s2_sign ? -low : low;
        clamp   = s2_sign ? MIN_SI : MAX_SI;

        res_data    = '0;
        res_inexact = 1'b0;
        res_ovf     = 1'b0;
        res_inv     = 1'b0;
        if (s2_nan) begin
            res_inv = 1'b1;
        end else if (s2_inf) begin
            res_ovf = 1'b1;
            if (SATURATE) res_data = clamp;
        end else if (!s2_zero) begin
            res_inexact = s2_guard | s2_sticky;
            res_ovf     = mag_ovf;
            res_data    = (SATURATE && mag_ovf) ? clamp : wrapped;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v1           <= 1'b0;
            v2           <= 1'b0;
            v3           <= 1'b0;
            out_data     <= '0;
            out_inexact  <= 1'b0;
            out_overflow <= 1'b0;
            out_invalid  <= 1'b0;
        end else begin
            if (en1) v1 <= in_valid;
            if (en2) v2 <= v1;
            if (en3) v3 <= v2;
            if (en1 && in_valid) begin
                s1_cls  <= f64_classify(in_bits);
                s1_mode <= rnd_mode_e'(in_mode);
            end
            if (en2 && v1) begin
                s2_sign   <= s1_cls.sign;
                s2_mode   <= s1_mode;
                s2_mag    <= al_mag;
                s2_guard  <= al_guard;
                s2_sticky <= al_sticky;
                s2_big    <= al_big;
                s2_zero   <= s1_cls.is_zero;
                s2_nan    <= s1_cls.is_nan;
                s2_inf    <= s1_cls.is_inf;
            end
            if (en3 && v2) begin
                out_data     <= res_data;
                out_inexact  <= res_inexact;
                out_overflow <= res_ovf;
                out_invalid  <= res_inv;
            end
        end
    end

endmodule

// File: tb/tb_f64_to_int_pipe.sv
// tb/tb_f64_to_int_pipe.sv - scoreboard bench over four width/overflow-policy configurations
module tb_f64_to_int_pipe;

    localparam logic [1:0] M_RNA = 2'd0, M_RTZ = 2'd1, M_FLOOR = 2'd2, M_CEIL = 2'd3;

    // Configuration index: 0 = 32 wrap, 1 = 64 wrap, 2 = 96 wrap, 3 = 32 saturate.
    typedef struct packed {
        logic [95:0]       tag;
        logic [3:0][95:0]  d;
        logic [3:0]        ovf;
        logic              inx;
        logic              inv;
        logic              lat;
        int                acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset, in_valid, out_ready;
    logic [63:0] in_bits;
    logic [1:0]  in_mode;
    logic [3:0]  ov, ori, oinx, oovf, oinv;
    logic [31:0] od0, od3;
    logic [63:0] od1;
    logic [95:0] od2;
    logic [3:0][95:0] got_d;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_wait;
    logic lat_chk = 1'b0;
    exp_t sbq[$];
    exp_t mon_e;
    logic held = 1'b0;
    logic [3:0][95:0] held_d;
    logic [11:0] held_f;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign in_ready = ori[2];
    assign got_d = {{64'd0, od3}, od2, {32'd0, od1}, {64'd0, od0}};

    f64_to_int_pipe #(.OUT_W(32), .SATURATE(1'b0)) u_w32 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ori[0]), .in_bits(in_bits),
        .in_mode(in_mode), .out_valid(ov[0]), .out_ready(out_ready), .out_data(od0),
        .out_inexact(oinx[0]), .out_overflow(oovf[0]), .out_invalid(oinv[0]));
    f64_to_int_pipe #(.OUT_W(64), .SATURATE(1'b0)) u_w64 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ori[1]), .in_bits(in_bits),
        .in_mode(in_mode), .out_valid(ov[1]), .out_ready(out_ready), .out_data(od1),
        .out_inexact(oinx[1]), .out_overflow(oovf[1]), .out_invalid(oinv[1]));
    f64_to_int_pipe #(.OUT_W(96), .SATURATE(1'b0)) u_w96 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ori[2]), .in_bits(in_bits),
        .in_mode(in_mode), .out_valid(ov[2]), .out_ready(out_ready), .out_data(od2),
        .out_inexact(oinx[2]), .out_overflow(oovf[2]), .out_invalid(oinv[2]));
    f64_to_int_pipe #(.OUT_W(32), .SATURATE(1'b1)) u_s32 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ori[3]), .in_bits(in_bits),
        .in_mode(in_mode), .out_valid(ov[3]), .out_ready(out_ready), .out_data(od3),
        .out_inexact(oinx[3]), .out_overflow(oovf[3]), .out_invalid(oinv[3]));

    logic in_ready;

    function automatic logic [95:0] dmask(input int k);
        if (k == 1) return {32'd0, {64{1'b1}}};
        if (k == 2) return {96{1'b1}};
        return {64'd0, {32{1'b1}}};
    endfunction

    // Expected results for an in-range-at-64-bits integer value.
    function automatic exp_t mk(input logic [95:0] tag, input longint v, input logic inx);
        exp_t        e;
        logic [95:0] s;
        logic        o32;
        e   = '0;
        s   = {{32{v[63]}}, v};
        o32 = (v > 64'sd2147483647) || (v < -64'sd2147483648);
        e.tag = tag;
        e.d[0] = s;
        e.d[1] = s;
        e.d[2] = s;
        e.d[3] = o32 ? ((v < 0) ? 96'h80000000 : 96'h7fffffff) : s;
        e.ovf = {o32, 2'b00, o32};
        e.inx = inx;
        return e;
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            checks++;
            if (ov !== {4{ov[0]}} || ori !== {4{ori[0]}}) begin
                errors++;
                $display("FAIL cfg_agree: out_valid=%b in_ready=%b required all bits equal", ov, ori);
            end
            if (ov[2] && out_ready) begin
                checks++;
                if (sbq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: data=%h required no output", od2);
                end else begin
                    checks--;
                    mon_e = sbq.pop_front();
                    for (int k = 0; k < 4; k++) begin
                        checks++;
                        if ((got_d[k] !== (mon_e.d[k] & dmask(k))) ||
                            ({oinx[k], oovf[k], oinv[k]} !== {mon_e.inx, mon_e.ovf[k], mon_e.inv})) begin
                            errors++;
                            $display("FAIL %s cfg%0d: data=%h inx/ovf/inv=%b%b%b required data=%h inx/ovf/inv=%b%b%b",
                                     mon_e.tag, k, got_d[k], oinx[k], oovf[k], oinv[k],
                                     mon_e.d[k] & dmask(k), mon_e.inx, mon_e.ovf[k], mon_e.inv);
                        end
                    end
                    if (mon_e.lat) begin
                        checks++;
                        if (cyc - mon_e.acc != 3) begin
                            errors++;
                            $display("FAIL latency %s: %0d cycles required 3", mon_e.tag, cyc - mon_e.acc);
                        end
                    end
                end
            end
        end
    end

    // A stalled result must not change until it is taken.
    always @(negedge clk) begin
        if (reset || !ov[2]) begin
            held = 1'b0;
        end else begin
            if (held) begin
                checks++;
                if (got_d !== held_d || {oinx, oovf, oinv} !== held_f) begin
                    errors++;
                    $display("FAIL stall_hold: data=%h required %h", got_d, held_d);
                end
            end
            held   = !out_ready;
            held_d = got_d;
            held_f = {oinx, oovf, oinv};
        end
    end

    task automatic send(input logic [63:0] b, input logic [1:0] m, input exp_t e);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_bits  = b;
        in_mode  = m;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        last_wait = n;
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout %s: in_ready=0 after %0d cycles required 1", e.tag, n);
        end else begin
            e.acc = cyc;
            e.lat = lat_chk;
            sbq.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain;
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d results outstanding required 0", sbq.size());
            sbq.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; in_valid = 1'b0; in_bits = '0; in_mode = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (ov !== 4'b0 || got_d !== '0 || (oinx | oovf | oinv) !== 4'b0 || ori !== 4'hf) begin
            errors++;
            $display("FAIL reset_state: valid=%b data=%h flags=%b%b%b ready=%b required all zero, ready=1111",
                     ov, got_d, oinx, oovf, oinv, ori);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_rna;
        lat_chk = 1'b1;
        send(64'hBFF8000000000000, M_RNA, mk("rna_m1p5", -2, 1'b1));
        send(64'hC015000000000000, M_RNA, mk("rna_m5p25", -5, 1'b1));
        send(64'h4004000000000000, M_RNA, mk("rna_2p5", 3, 1'b1));
        send($realtobits(3.0), M_RNA, mk("rna_3", 3, 1'b0));
        wait_drain();
    endtask

    task automatic test_modes;
        lat_chk = 1'b1;
        send(64'hBFF8000000000000, M_RTZ, mk("rtz_m1p5", -1, 1'b1));
        send(64'hBFF8000000000000, M_FLOOR, mk("flr_m1p5", -2, 1'b1));
        send(64'hBFF8000000000000, M_CEIL, mk("ceil_m1p5", -1, 1'b1));
        send(64'h4004000000000000, M_RTZ, mk("rtz_2p5", 2, 1'b1));
        send(64'h4004000000000000, M_FLOOR, mk("flr_2p5", 2, 1'b1));
        send(64'h4004000000000000, M_CEIL, mk("ceil_2p5", 3, 1'b1));
        send(64'h3FD3333333333333, M_CEIL, mk("ceil_0p3", 1, 1'b1));
        send(64'h3FD3333333333333, M_FLOOR, mk("flr_0p3", 0, 1'b1));
        wait_drain();
    endtask

    task automatic test_boundary;
        lat_chk = 1'b1;
        send($realtobits(2147483647.5), M_RNA, mk("rna_max32", 64'sd2147483648, 1'b1));
        send($realtobits(-2147483648.0), M_RTZ, mk("rtz_min32", -64'sd2147483648, 1'b0));
        send($realtobits(-2147483648.5), M_RTZ, mk("rtz_min32h", -64'sd2147483648, 1'b1));
        send($realtobits(-2147483648.5), M_FLOOR, mk("flr_min32h", -64'sd2147483649, 1'b1));
        wait_drain();
    endtask

    task automatic test_large;
        logic [63:0] pb;
        exp_t        e;
        lat_chk = 1'b1;
        pb = $realtobits(12456789012345678912345.5);
        e = '0;
        e.tag = "big_pos";
        e.d[0] = 96'he5400000;
        e.d[1] = 96'h48acb7d4e5400000;
        e.d[2] = 96'h000002a348acb7d4e5400000;
        e.d[3] = 96'h7fffffff;
        e.ovf = 4'b1011;
        send(pb, M_RTZ, e);
        e.tag = "big_neg";
        e.d[0] = 96'h1ac00000;
        e.d[1] = 96'hb753482b1ac00000;
        e.d[2] = 96'hfffffd5cb753482b1ac00000;
        e.d[3] = 96'h80000000;
        send(pb ^ 64'h8000000000000000, M_RNA, e);
        wait_drain();
    endtask

    task automatic test_special;
        exp_t e;
        lat_chk = 1'b1;
        e = '0;
        e.tag = "pos_inf";
        e.d[3] = 96'h7fffffff;
        e.ovf = 4'b1111;
        send(64'h7FF0000000000000, M_RNA, e);
        e.tag = "huge_2e1000";
        send(64'h7E70000000000000, M_FLOOR, e);
        e.tag = "neg_inf";
        e.d[3] = 96'h80000000;
        send(64'hFFF0000000000000, M_CEIL, e);
        e = '0;
        e.tag = "nan";
        e.inv = 1'b1;
        send(64'h7FF8000000000000, M_RNA, e);
        send(64'h8000000000000000, M_FLOOR, mk("neg_zero", 0, 1'b0));
        send(64'h0000000000000001, M_CEIL, mk("subn_ceil", 1, 1'b1));
        wait_drain();
    endtask

    task automatic test_backpressure;
        longint k, r;
        logic [1:0] m;
        lat_chk = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            k = longint'(i) - 4;
            m = 2'(i);
            case (m)
                M_RNA:   r = (k >= 0) ? k + 1 : k;
                M_RTZ:   r = (k >= 0) ? k : k + 1;
                M_FLOOR: r = k;
                default: r = k + 1;
            endcase
            if (i == 3) begin
                in_valid = 1'b1;
                @(negedge clk);
                checks++;
                if (in_ready !== 1'b0 || ov[2] !== 1'b1) begin
                    errors++;
                    $display("FAIL full_stall: in_ready=%b out_valid=%b required 0 1", in_ready, ov[2]);
                end
                fork
                    begin
                        repeat (2) @(posedge clk);
                        #1 out_ready = 1'b1;
                    end
                join_none
            end
            send($realtobits(real'(k) + 0.5), m, mk("bp", r, 1'b1));
            if (i < 3) begin
                checks++;
                if (last_wait != 0) begin
                    errors++;
                    $display("FAIL bp_accept%0d: waited %0d cycles required 0", i, last_wait);
                end
            end
        end
        wait_drain();
        out_ready = 1'b1;
    endtask

    task automatic test_reset_mid;
        out_ready = 1'b0;
        lat_chk = 1'b0;
        send($realtobits(1.0), M_RTZ, mk("rst_a", 1, 1'b0));
        send($realtobits(2.0), M_RTZ, mk("rst_b", 2, 1'b0));
        send($realtobits(3.0), M_RTZ, mk("rst_c", 3, 1'b0));
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        sbq.delete();
        @(negedge clk);
        checks++;
        if (ov !== 4'b0 || got_d !== '0 || (oinx | oovf | oinv) !== 4'b0 || ori !== 4'hf) begin
            errors++;
            $display("FAIL mid_reset: valid=%b data=%h flags=%b%b%b ready=%b required all zero, ready=1111",
                     ov, got_d, oinx, oovf, oinv, ori);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        lat_chk = 1'b1;
        send($realtobits(-7.75), M_RNA, mk("post_rst", -8, 1'b1));
        wait_drain();
    endtask

    initial begin
        test_reset();
        test_rna();
        test_modes();
        test_boundary();
        test_large();
        test_special();
        test_backpressure();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

endmodule
